// File: rtl/iir_coeff_loader.sv
// Streams NC = 2*ORD coefficient words from a valid/ready source into an IIR filter's coefficient port.
// Define IIR_COEFF_LOADER_CHKSUM_EN to verify a trailing modulo-2^CW checksum word before signalling done.
module iir_coeff_loader #(
    parameter int ORD      = 10,
    parameter int COEFF_WH = 2,
    parameter int COEFF_FR = 14,
    localparam int NC = ORD * 2,
    localparam int CW = COEFF_WH + COEFF_FR,
    localparam int AW = $clog2(NC)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          s_valid,
    input  logic [CW-1:0] s_data,
    output logic          s_ready,
    output logic          c_we,
    output logic [AW-1:0] c_addr,
    output logic [CW-1:0] c_in,
    output logic          busy,
    output logic          done,
    output logic          err
);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
`ifdef IIR_COEFF_LOADER_CHKSUM_EN
        CHK,
`endif
        FIN
    } state_t;

    localparam logic [AW-1:0] LAST = AW'(NC - 1);

    state_t        state;
    logic [AW-1:0] cnt;

`ifdef IIR_COEFF_LOADER_CHKSUM_EN
    logic [CW-1:0] sum;
    logic          err_r;

    assign err = err_r;
`else
    assign err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            s_ready <= 1'b0;
            c_we    <= 1'b0;
            c_addr  <= '0;
            c_in    <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            cnt     <= '0;
`ifdef IIR_COEFF_LOADER_CHKSUM_EN
            sum     <= '0;
            err_r   <= 1'b0;
`endif
        end else begin
            c_we <= 1'b0;
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state   <= LOAD;
                        s_ready <= 1'b1;
                        busy    <= 1'b1;
                        cnt     <= '0;
`ifdef IIR_COEFF_LOADER_CHKSUM_EN
                        sum     <= '0;
                        err_r   <= 1'b0;
`endif
                    end
                end
                LOAD: begin
                    if (s_valid && s_ready) begin
                        c_we   <= 1'b1;
                        c_in   <= s_data;
                        c_addr <= cnt;
                        cnt    <= cnt + AW'(1);
`ifdef IIR_COEFF_LOADER_CHKSUM_EN
                        sum    <= sum + s_data;
`endif
                        // Last word: the write still lands next cycle, alongside done when no check follows.
                        if (cnt == LAST) begin
`ifdef IIR_COEFF_LOADER_CHKSUM_EN
                            state   <= CHK;
`else
                            state   <= FIN;
                            s_ready <= 1'b0;
                            busy    <= 1'b0;
                            done    <= 1'b1;
`endif
                        end
                    end
                end
`ifdef IIR_COEFF_LOADER_CHKSUM_EN
                CHK: begin
                    // Checksum word is consumed but never written to the filter.
                    if (s_valid && s_ready) begin
                        s_ready <= 1'b0;
                        busy    <= 1'b0;
                        if (s_data == sum) begin
                            state <= FIN;
                            done  <= 1'b1;
                        end else begin
                            state <= IDLE;
                            err_r <= 1'b1;
                        end
                    end
                end
`endif
                FIN: begin
                    state <= IDLE;
                end
                default: begin
                    state   <= IDLE;
                    s_ready <= 1'b0;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_iir_coeff_loader.sv
// Self-checking bench for iir_coeff_loader: table of load scenarios driven through a word-level model
// with a write scoreboard; checksum scenarios adapt to IIR_COEFF_LOADER_CHKSUM_EN.
module tb_iir_coeff_loader;

    localparam int NC = 20;
    localparam int CW = 16;
    localparam int AW = 5;

    localparam int M_IDLE = 0;
    localparam int M_LOAD = 1;
    localparam int M_CHK  = 2;
    localparam int M_FIN  = 3;

    logic          clk;
    logic          rst;
    logic          start;
    logic          s_valid;
    logic [CW-1:0] s_data;
    logic          s_ready;
    logic          c_we;
    logic [AW-1:0] c_addr;
    logic [CW-1:0] c_in;
    logic          busy;
    logic          done;
    logic          err;

    iir_coeff_loader #(
        .ORD(10),
        .COEFF_WH(2),
        .COEFF_FR(14)
    ) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .s_valid(s_valid),
        .s_data(s_data),
        .s_ready(s_ready),
        .c_we(c_we),
        .c_addr(c_addr),
        .c_in(c_in),
        .busy(busy),
        .done(done),
        .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [AW-1:0] a;
        logic [CW-1:0] d;
    } wr_t;

    typedef struct {
        int            pat;       // 0: back-to-back, 1: valid toggles every cycle
        int            start_at;  // word index carrying a spurious start, -1 none
        int            rst_at;    // reset asserted with the word after this index, -1 none
        logic [CW-1:0] chk_word;  // word presented after the 20 coefficients
        int            exp_wr;
        int            exp_done;
        logic          exp_err;
    } vec_t;

    wr_t           q[$];
    int            errors = 0;
    int            checks = 0;
    int            mst = M_IDLE;
    int            mcnt = 0;
    logic [CW-1:0] msum = '0;
    logic          merr = 1'b0;
    logic [AW-1:0] last_a = '0;
    logic [CW-1:0] last_d = '0;
    int            wr_cnt = 0;
    int            done_cnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_reset_vals();
        chk("rst_s_ready", 32'(s_ready), 0);
        chk("rst_c_we", 32'(c_we), 0);
        chk("rst_c_addr", 32'(c_addr), 0);
        chk("rst_c_in", 32'(c_in), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_err", 32'(err), 0);
    endtask

    // Advance one clock: update the model from the driven inputs, then compare after the edge.
    task automatic step();
        wr_t w;
        if (rst) begin
            mst = M_IDLE; mcnt = 0; msum = '0; merr = 1'b0;
            q.delete(); last_a = '0; last_d = '0;
        end else begin
            case (mst)
                M_IDLE: if (start) begin
                    mst = M_LOAD; mcnt = 0; msum = '0; merr = 1'b0;
                end
                M_LOAD: if (s_valid) begin
                    q.push_back('{a: AW'(mcnt), d: s_data});
                    msum = msum + s_data;
                    if (mcnt == NC - 1) begin
`ifdef IIR_COEFF_LOADER_CHKSUM_EN
                        mst = M_CHK;
`else
                        mst = M_FIN;
`endif
                    end
                    mcnt++;
                end
                M_CHK: if (s_valid) begin
                    if (s_data == msum) mst = M_FIN;
                    else begin merr = 1'b1; mst = M_IDLE; end
                end
                default: mst = M_IDLE;
            endcase
        end
        @(posedge clk);
        #1;
        chk("s_ready", 32'(s_ready), 32'(mst == M_LOAD || mst == M_CHK));
        chk("busy", 32'(busy), 32'(mst == M_LOAD || mst == M_CHK));
        chk("done", 32'(done), 32'(mst == M_FIN));
        chk("err", 32'(err), 32'(merr));
        chk("c_we", 32'(c_we), 32'(q.size() != 0));
        if (c_we) wr_cnt++;
        if (done) done_cnt++;
        if (c_we && q.size() != 0) begin
            w = q.pop_front();
            chk("c_addr", 32'(c_addr), 32'(w.a));
            chk("c_in", 32'(c_in), 32'(w.d));
            last_a = w.a;
            last_d = w.d;
        end else if (!c_we) begin
            chk("hold_c_addr", 32'(c_addr), 32'(last_a));
            chk("hold_c_in", 32'(c_in), 32'(last_d));
        end
    endtask

    task automatic run_load(input vec_t v);
        wr_cnt = 0;
        done_cnt = 0;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int w = 0; w < NC; w++) begin
            if (v.pat == 1) begin
                s_valid = 1'b0;
                s_data = 16'hDEAD;
                step();
            end
            s_valid = 1'b1;
            s_data = CW'(w + 1);
            start = (w == v.start_at);
            rst = (v.rst_at >= 0 && w == v.rst_at + 1);
            step();
            start = 1'b0;
            if (rst) begin
                chk_reset_vals();
                rst = 1'b0;
                s_valid = 1'b0;
                step();
                return;
            end
        end
        s_valid = 1'b1;
        s_data = v.chk_word;
        step();
        s_valid = 1'b0;
        s_data = '0;
        repeat (4) step();
    endtask

    initial begin
        vec_t tbl[7];
        tbl[0] = '{pat: 0, start_at: -1, rst_at: -1, chk_word: 16'h00D2, exp_wr: 20, exp_done: 1, exp_err: 1'b0};
        tbl[1] = '{pat: 1, start_at: -1, rst_at: -1, chk_word: 16'h00D2, exp_wr: 20, exp_done: 1, exp_err: 1'b0};
        tbl[2] = '{pat: 0, start_at: 7,  rst_at: -1, chk_word: 16'h00D2, exp_wr: 20, exp_done: 1, exp_err: 1'b0};
        tbl[3] = '{pat: 0, start_at: -1, rst_at: 10, chk_word: 16'h00D2, exp_wr: 11, exp_done: 0, exp_err: 1'b0};
        tbl[4] = '{pat: 0, start_at: -1, rst_at: -1, chk_word: 16'h00D2, exp_wr: 20, exp_done: 1, exp_err: 1'b0};
`ifdef IIR_COEFF_LOADER_CHKSUM_EN
        tbl[5] = '{pat: 0, start_at: -1, rst_at: -1, chk_word: 16'h00D3, exp_wr: 20, exp_done: 0, exp_err: 1'b1};
`else
        tbl[5] = '{pat: 0, start_at: -1, rst_at: -1, chk_word: 16'h00D3, exp_wr: 20, exp_done: 1, exp_err: 1'b0};
`endif
        tbl[6] = '{pat: 1, start_at: -1, rst_at: -1, chk_word: 16'h00D2, exp_wr: 20, exp_done: 1, exp_err: 1'b0};

        rst = 1'b1;
        start = 1'b1;
        s_valid = 1'b1;
        s_data = 16'h1234;
        step();
        step();
        chk_reset_vals();
        start = 1'b0;
        s_valid = 1'b0;
        s_data = '0;
        rst = 1'b0;
        step();

        for (int i = 0; i < 7; i++) begin
            run_load(tbl[i]);
            chk($sformatf("writes_%0d", i), 32'(wr_cnt), 32'(tbl[i].exp_wr));
            chk($sformatf("dones_%0d", i), 32'(done_cnt), 32'(tbl[i].exp_done));
            chk($sformatf("err_end_%0d", i), 32'(err), 32'(tbl[i].exp_err));
            if (i == 5) begin
                // Error flag must survive idle cycles until the next start.
                repeat (3) step();
                chk("err_sticky", 32'(err), 32'(tbl[i].exp_err));
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
